// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
//   state_t     : controller FSM encoding (IDLE / REQ / SERV)
//   NUM_IRQ_DEF : default number of request lines
//   TIMEOUT_DEF : default acknowledge timeout in cycles
//   lowest_set  : index of the lowest set bit of an up-to-8-bit vector
package intc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam int NUM_IRQ_DEF = 4;
  localparam int TIMEOUT_DEF = 255;

  // Scan from the top so the last hit is the lowest index (highest priority).
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one request line.
//   clk, rst : clock, synchronous active-high reset
//   d        : raw synchronous input
//   rise     : 1 when d=1 and the previous sample was 0
// The previous sample resets to 0, so a line held high through reset
// release reports a rising edge on the first cycle after reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/interrupt_controller.sv
// Priority interrupt controller with a request / acknowledge / end-of-
// interrupt handshake toward a processor.
//   clk, rst    : clock, synchronous active-high reset
//   irq         : raw request lines, index 0 highest priority
//   maskWe      : mask write strobe, maskIn = new mask (1 enables a source)
//   intAck      : acknowledge pulse, eoi = end-of-interrupt pulse
//   INT         : registered interrupt request (high only in REQ)
//   vector      : index of the source being requested or serviced
//   pending     : latched request edges, independent of the mask
//   timeoutFlag : sticky acknowledge-timeout indicator
// Optional feature: define INTC_TIMEOUT_EN to abandon a REQ that is not
// acknowledged within TIMEOUT cycles; otherwise REQ waits indefinitely.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         irq,
  input  logic                       maskWe,
  input  logic [NUM_IRQ-1:0]         maskIn,
  input  logic                       intAck,
  input  logic                       eoi,
  output logic                       INT,
  output logic [$clog2(NUM_IRQ)-1:0] vector,
  output logic [NUM_IRQ-1:0]         pending,
  output logic                       timeoutFlag
);
  localparam int VW = $clog2(NUM_IRQ);

  if (NUM_IRQ < 2 || NUM_IRQ > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("interrupt_controller: NUM_IRQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t             state;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [2:0]         sel;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_edge
    edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (irq[i]),
      .rise (rise[i])
    );
  end

  assign active  = pending & mask;
  assign sel     = lowest_set(8'(active));
  assign ack_clr = (state == REQ && intAck) ? (NUM_IRQ'(1) << vector) : '0;

  // A new edge on the acknowledged source wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~ack_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst)         mask <= '1;
    else if (maskWe) mask <= maskIn;
  end

`ifdef INTC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign timeoutFlag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      INT    <= 1'b0;
      vector <= '0;
`ifdef INTC_TIMEOUT_EN
      cnt         <= '0;
      timeoutFlag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (|active) begin
          vector <= sel[VW-1:0];
          state  <= REQ;
          INT    <= 1'b1;
`ifdef INTC_TIMEOUT_EN
          cnt    <= '0;
`endif
        end
        // vector stays frozen here; pending[vector] is cleared by ack_clr.
        REQ: if (intAck) begin
          state <= SERV;
          INT   <= 1'b0;
        end
`ifdef INTC_TIMEOUT_EN
        // cnt counts REQ cycles already spent, so INT is high TIMEOUT cycles.
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state       <= IDLE;
          INT         <= 1'b0;
          timeoutFlag <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        SERV: if (eoi) state <= IDLE;
        default: begin
          state <= IDLE;
          INT   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
  localparam int N  = 4;
  localparam int TO = 8;
`ifdef INTC_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, maskWe, intAck, eoi;
  logic [N-1:0] irq, maskIn;
  logic         INT, timeoutFlag;
  logic [1:0]   vector;
  logic [N-1:0] pending;

  int n_chk = 0;
  int n_fail = 0;

  interrupt_controller #(.NUM_IRQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .irq(irq), .maskWe(maskWe), .maskIn(maskIn),
    .intAck(intAck), .eoi(eoi), .INT(INT), .vector(vector),
    .pending(pending), .timeoutFlag(timeoutFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the controller is doing in terms of the
  // handshake (nothing / waiting for ack / in service) and which source.
  logic [N-1:0] m_pend, m_mask, m_prev, m_rise, m_next;
  int  m_phase;    // 0 nothing, 1 waiting for ack, 2 in service
  int  m_vec, m_wait;
  bit  m_flag, started;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_pend = '0; m_mask = '1; m_prev = '0; m_phase = 0;
      m_vec = 0; m_wait = 0; m_flag = 1'b0;
    end else begin
      m_rise = irq & ~m_prev;
      m_next = m_pend | m_rise;
      if (m_phase == 0) begin
        if ((m_pend & m_mask) != 0) begin
          m_vec = lowest(m_pend & m_mask); m_phase = 1; m_wait = 0;
        end
      end else if (m_phase == 1) begin
        if (intAck) begin
          if (!m_rise[m_vec]) m_next[m_vec] = 1'b0;
          m_phase = 2;
        end else if (TO_ON) begin
          m_wait++;
          if (m_wait == TO) begin m_phase = 0; m_flag = 1'b1; end
        end
      end else if (eoi) begin
        m_phase = 0;
      end
      m_pend = m_next;
      m_prev = irq;
      if (maskWe) m_mask = maskIn;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model INT", int'(INT), int'(m_phase == 1));
      chk("model vector", int'(vector), m_vec);
      chk("model pending", int'(pending), int'(m_pend));
      chk("model timeoutFlag", int'(timeoutFlag), int'(m_flag));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ack_eoi();
    intAck = 1'b1; step(); intAck = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 4'b0100; maskWe = 1'b0; maskIn = '0;
    intAck = 1'b0; eoi = 1'b0;
    step(); step();
    chk("reset INT", int'(INT), 0);
    chk("reset pending", int'(pending), 0);
    chk("reset vector", int'(vector), 0);
    chk("reset timeoutFlag", int'(timeoutFlag), 0);

    // Line held high from cycle 0 through reset release.
    rst = 1'b0;
    step();
    chk("s1 pending", int'(pending), 4'b0100);
    chk("s1 INT before", int'(INT), 0);
    step();
    chk("s1 INT", int'(INT), 1);
    chk("s1 vector", int'(vector), 2);
    intAck = 1'b1; step(); intAck = 1'b0;
    chk("s1 INT after ack", int'(INT), 0);
    chk("s1 pending after ack", int'(pending), 0);
    eoi = 1'b1; step(); eoi = 1'b0;
    irq = 4'b0010; step(); irq = '0; step();
    chk("s1 back to idle INT", int'(INT), 1);
    chk("s1 back to idle vector", int'(vector), 1);
    ack_eoi();

    // Higher priority arrives while a lower one is being requested.
    irq = 4'b1000; step();
    irq = 4'b1001; step();
    chk("s2 INT", int'(INT), 1);
    chk("s2 vector", int'(vector), 3);
    step();
    chk("s2 vector frozen", int'(vector), 3);
    ack_eoi();
    step();
    chk("s2 reassert INT", int'(INT), 1);
    chk("s2 reassert vector", int'(vector), 0);
    irq = '0;
    ack_eoi();

    // Masked source latches pending but does not request.
    maskWe = 1'b1; maskIn = 4'b1110; step(); maskWe = 1'b0;
    irq = 4'b0001; step(); irq = '0; step();
    chk("s3 pending masked", int'(pending), 4'b0001);
    chk("s3 INT masked", int'(INT), 0);
    step();
    chk("s3 INT still masked", int'(INT), 0);
    maskWe = 1'b1; maskIn = 4'b1111; step(); maskWe = 1'b0;
    chk("s3 INT mask write cycle", int'(INT), 0);
    step();
    chk("s3 INT unmasked", int'(INT), 1);
    chk("s3 vector", int'(vector), 0);
    ack_eoi();

    // New edge on the acknowledged source coincides with intAck.
    irq = 4'b0010; step(); irq = '0; step();
    chk("s4 INT", int'(INT), 1);
    chk("s4 vector", int'(vector), 1);
    irq = 4'b0010; intAck = 1'b1; step(); intAck = 1'b0;
    chk("s4 pending kept", int'(pending), 4'b0010);
    chk("s4 INT after ack", int'(INT), 0);
    intAck = 1'b1; step(); intAck = 1'b0;   // ack in SERV is ignored
    chk("s4 ack ignored in SERV", int'(pending), 4'b0010);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    chk("s4 reassert INT", int'(INT), 1);
    chk("s4 reassert vector", int'(vector), 1);
    irq = '0;
    ack_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;         // eoi in IDLE is ignored

    // Unacknowledged request.
    irq = 4'b0100; step(); irq = '0; step();
    chk("s5 INT", int'(INT), 1);
    repeat (TO - 1) step();
    chk("s5 INT last wait cycle", int'(INT), 1);
    step();
    if (TO_ON) begin
      chk("s5 INT timed out", int'(INT), 0);
      chk("s5 timeoutFlag", int'(timeoutFlag), 1);
      chk("s5 pending kept", int'(pending), 4'b0100);
      step();
      chk("s5 INT reassert", int'(INT), 1);
      chk("s5 vector", int'(vector), 2);
    end else begin
      repeat (12) step();
      chk("s5 INT waits", int'(INT), 1);
      chk("s5 timeoutFlag tied", int'(timeoutFlag), 0);
    end
    ack_eoi();

    // Reset while in service; mask must return to all ones.
    maskWe = 1'b1; maskIn = 4'b0010; step(); maskWe = 1'b0;
    irq = 4'b1010; step(); irq = '0; step();
    chk("s6 vector", int'(vector), 1);
    intAck = 1'b1; step(); intAck = 1'b0;
    chk("s6 pending in SERV", int'(pending), 4'b1000);
    rst = 1'b1; step(); rst = 1'b0;
    chk("s6 INT after rst", int'(INT), 0);
    chk("s6 pending after rst", int'(pending), 0);
    chk("s6 vector after rst", int'(vector), 0);
    chk("s6 timeoutFlag after rst", int'(timeoutFlag), 0);
    irq = 4'b1000; step(); irq = '0; step();
    chk("s6 mask reset INT", int'(INT), 1);
    chk("s6 mask reset vector", int'(vector), 3);
    ack_eoi();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 4, SHALL set the number of request lines; legal values are 2 to 8.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the acknowledge timeout in cycles; it is used only when INTC_TIMEOUT_EN is defined.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset; synchronous, active-high.
REQ-005 irq  in  NUM_IRQ  SHALL be the raw request lines, synchronous to clk; index 0 has the highest priority.
REQ-006 maskWe  in  1  SHALL be the mask write strobe.
REQ-007 maskIn  in  NUM_IRQ  SHALL be the new mask value; 1 enables the source.
REQ-008 intAck  in  1  SHALL be the one-cycle acknowledge pulse from the processor control unit.
REQ-009 eoi  in  1  SHALL be the one-cycle end-of-interrupt pulse.
REQ-010 INT  out  1  SHALL be the registered interrupt request that drives the processor INT input.
REQ-011 vector  out  $clog2(NUM_IRQ)  SHALL be the index of the source being requested or serviced.
REQ-012 pending  out  NUM_IRQ  SHALL be the pending register.
REQ-013 timeoutFlag  out  1  SHALL be the sticky acknowledge-timeout indicator.

Function
REQ-014 A per-bit rising edge on irq (irq=1 with the previous sample 0) SHALL set pending[i] at that clock edge.
REQ-015 The pending bits SHALL be latched regardless of mask; the mask gates selection only, and a mask write takes effect on the next cycle.
REQ-016 The FSM SHALL have three states, IDLE, REQ and SERV; INT=1 only in REQ.
REQ-017 In IDLE, if (pending & mask) is nonzero, the block SHALL latch vector as the lowest set index and enter REQ on the next edge; INT therefore rises one cycle after pending is set.
REQ-018 In REQ, vector SHALL stay frozen even if a higher-priority request arrives or the source is masked.
REQ-019 In REQ, intAck=1 SHALL clear pending[vector] and enter SERV, with INT=0 from the next cycle.
REQ-020 In SERV, eoi=1 SHALL return the FSM to IDLE; the next request can assert INT no earlier than the following cycle.
REQ-021 intAck outside REQ and eoi outside SERV SHALL be ignored.
REQ-022 If an edge for pending[vector] coincides with the intAck clear, the set SHALL win and the bit stays 1.
REQ-023 Multiple pending sources SHALL be served one per REQ/SERV cycle in priority order.

Reset
REQ-024 When rst=1, the block SHALL force state=IDLE, INT=0, vector=0, pending=0, mask=all ones, the irq previous-sample register=0, timeoutFlag=0 and the timeout counter=0.
REQ-025 Reset mid-REQ or mid-SERV SHALL drop the request without an acknowledge; an irq line held high through reset release SHALL count as a rising edge.

Configuration
REQ-026 With the macro INTC_TIMEOUT_EN defined, a counter SHALL clear on entering REQ and, if it reaches TIMEOUT without intAck, return the FSM to IDLE with INT=0, keep pending[vector] set, and set timeoutFlag sticky until rst.
REQ-027 Without INTC_TIMEOUT_EN, REQ SHALL wait indefinitely, timeoutFlag SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-028 The shared package intc_pkg SHALL hold the state encoding (IDLE/REQ/SERV) and the defaults NUM_IRQ=4 and TIMEOUT=255.
REQ-029 Per-bit rising-edge detection SHALL be a sub-module named edge_detect, instantiated once per irq line.

Verification
REQ-030 The bench SHALL check: irq=4'b0100 held from cycle 0 -> pending=4'b0100, INT=1 next cycle with vector=2; intAck -> INT=0, pending=0; eoi -> IDLE.
REQ-031 The bench SHALL check: irq 4'b1000 then 4'b1001 one cycle later, while in REQ -> vector stays 3; after ack/eoi, INT re-asserts with vector=0.
REQ-032 The bench SHALL check: maskIn=4'b1110 with maskWe, then irq[0] pulse -> pending[0]=1, INT stays 0; after mask=4'b1111, INT=1 with vector=0.
REQ-033 The bench SHALL check: new irq[1] edge on the same cycle as intAck for vector=1 -> pending[1] stays 1, INT re-asserts after eoi.
REQ-034 The bench SHALL check: with INTC_TIMEOUT_EN and TIMEOUT=8, no intAck -> INT falls after 8 cycles, timeoutFlag=1, pending bit kept, INT re-asserts the next cycle.
REQ-035 The bench SHALL check: rst pulsed while in SERV -> INT=0, pending=0, mask=all ones, state=IDLE on the next cycle.
